irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Interrupt controller sitting directly upstream of the single-cycle CPU with exception/interrupt support.
- Collects NUM_IRQ asynchronous external request lines, synchronises and edge-detects them, and latches them as pending.
- Applies a CPU-writable enable mask and priority-encodes the result.
- Drives a single interrupt request plus cause code into the CPU, handshaking on acknowledge (Inta) and on return-from-exception (Eret).

Parameters:
- NUM_IRQ, 8, number of external interrupt lines (2..32).
- ID_W, 3, width of cause code; must satisfy 2**ID_W >= NUM_IRQ.

Ports:
- Clk  in  1  system clock, all state updates on rising edge.
- Clr  in  1  reset, asynchronous, active-high; clears all state immediately.
- IrqIn  in  NUM_IRQ  raw asynchronous request lines; rising edge = event.
- EnWe  in  1  enable-mask write strobe from CPU.
- EnWdata  in  NUM_IRQ  new enable mask, bit i = 1 enables line i.
- EnRdata  out  NUM_IRQ  current enable mask.
- Pending  out  NUM_IRQ  current pending register (unmasked).
- Intr  out  1  interrupt request to CPU.
- IntCause  out  ID_W  index of the requested line; valid while Intr = 1 or InService = 1.
- Inta  in  1  CPU acknowledge, sampled only in REQ.
- Eret  in  1  CPU return-from-exception, sampled only in INSVC.
- InService  out  1  high while the CPU is servicing an interrupt.

Behaviour:
- Reset values (on Clr = 1):
  - sync flops, edge history, Pending, enable mask = 0.
  - State = IDLE, Intr = 0, InService = 0, IntCause = 0.
- Per-line front end:
  - Two-flop synchroniser, then edge history flop; edge_i = sync2_i & ~hist_i.
  - IrqIn_i rising before clock edge k gives Pending_i = 1 after edge k+2.
  - Level held high produces exactly one event; the line must drop and re-rise for a new event.
- Pending register:
  - Bit i is set at any edge where edge_i = 1, independent of mask and state.
  - Bit i is cleared only by acknowledge of cause i.
  - Simultaneous set and clear of the same bit: set wins (bit stays 1).
- Masked request:
  - req = Pending & enable.
  - Priority: lowest index wins; cause = index of lowest set bit of req.
- Enable mask:
  - On EnWe, the mask takes EnWdata at the edge.
  - Writes take effect for selection from the next cycle.
- State machine, encoded in the shared package (IDLE, REQ, INSVC):
  - IDLE: if req != 0 at edge, latch cause into IntCause and go to REQ. Intr = 0, InService = 0.
  - REQ: Intr = 1. If Inta = 1 at edge, clear Pending[IntCause] and go to INSVC. IntCause is frozen in REQ; a higher-priority arrival or a mask change does not retarget or withdraw the request.
  - INSVC: Intr = 0, InService = 1, IntCause held. If Eret = 1 at edge, go to IDLE. No nesting.
  - Back in IDLE, a new request is raised no earlier than the edge after Eret.
- Latency:
  - From IrqIn rise before edge k to Intr = 1: Intr high after edge k+3, provided the line is enabled and state is IDLE.
  - From Inta to InService: 1 edge.
- Ignored inputs: Inta outside REQ, and Eret outside INSVC.
- Clr asserted mid-operation (any state) returns to IDLE immediately and discards pending events and mask; no partial handshake survives.
- Outputs Intr, InService, EnRdata and Pending are driven directly from registers and state decode; no combinational path from IrqIn to Intr.

Decomposition:
- Shared package irq_pkg holds:
  - state typedef {IDLE, REQ, INSVC};
  - default NUM_IRQ and ID_W constants.
- Sub-module irq_sync_edge, one instance per line: synchroniser, history flop and edge output, with Clk/Clr.
- Priority encoder and FSM live in irq_controller.

Test Plan:
- Reset and mask: hold Clr, pulse IrqIn = 8'h01, release Clr; no EnWe -> Pending = 8'h01 and Intr stays 0. Then EnWe with 8'h01 -> Intr = 1, IntCause = 0.
- Priority: enable 8'hFF, raise IrqIn[5] and IrqIn[2] on the same cycle -> IntCause = 2. Then Inta -> Pending = 8'h20. Then Eret -> Intr rises again with IntCause = 5.
- Latency: IrqIn[3] rises before edge k, enable = 8'h08 -> Pending[3] = 1 after k+2, Intr = 1 after k+3. Inta at k+4 -> InService = 1 and Pending = 0 after k+4.
- Frozen cause: in REQ with IntCause = 4, raise IrqIn[1] -> IntCause stays 4. Then Inta -> Pending = 8'h02. Then Eret -> next IntCause = 1.
- Set-wins and one-shot: IrqIn[0] re-edges on the same cycle as Inta for cause 0 -> Pending[0] remains 1. IrqIn[0] held high 20 cycles -> only one event is recorded.
- Async reset mid-service: in INSVC, assert Clr between clock edges -> InService, Intr and Pending go to 0 immediately, state is IDLE, and a later Eret is ignored.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and default sizing for the interrupt controller.
package irq_pkg;

  localparam int NUM_IRQ_DEF = 8;
  localparam int ID_W_DEF    = 3;

  // Handshake states. IDLE waits for a request, REQ drives Intr until the CPU
  // acknowledges, and INSVC holds until the CPU returns from the exception.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    INSVC = 2'd2
  } state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line front end: two-flop synchroniser followed by an edge-history flop.
// Rise is high for exactly one cycle for each low-to-high transition of IrqIn.
module irq_sync_edge (
  input  logic Clk,
  input  logic Clr,
  input  logic IrqIn,
  output logic Rise
);

  logic sync1;
  logic sync2;
  logic hist;

  // Synchronise the raw line and remember the previous synchronised level.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the three flops shift as one
      // pipeline; blocking ones would collapse them into a single stage.
      sync1 <= IrqIn;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign Rise = sync2 & ~hist;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches edge events as pending, masks them with a
// CPU-writable enable register, picks the lowest-index request and runs the
// Intr / Inta / Eret handshake with the CPU.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int ID_W    = ID_W_DEF
) (
  input  logic               Clk,
  input  logic               Clr,
  input  logic [NUM_IRQ-1:0] IrqIn,
  input  logic               EnWe,
  input  logic [NUM_IRQ-1:0] EnWdata,
  output logic [NUM_IRQ-1:0] EnRdata,
  output logic [NUM_IRQ-1:0] Pending,
  output logic               Intr,
  output logic [ID_W-1:0]    IntCause,
  input  logic               Inta,
  input  logic               Eret,
  output logic               InService
);

  logic [NUM_IRQ-1:0] edges;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] enable_q;
  logic [NUM_IRQ-1:0] req;
  logic [NUM_IRQ-1:0] clr_vec;
  logic               req_any;
  logic [ID_W-1:0]    prio_idx;
  logic [ID_W-1:0]    cause_q;
  logic [ID_W-1:0]    cause_nxt;
  logic               ack;
  state_t             state_q;
  state_t             state_nxt;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    irq_sync_edge u_sync_edge (
      .Clk   (Clk),
      .Clr   (Clr),
      .IrqIn (IrqIn[g]),
      .Rise  (edges[g])
    );
  end

  assign req     = pending_q & enable_q;
  assign req_any = |req;

  // Lowest set bit of the masked request wins; scanning downwards lets the
  // last assignment be the lowest index.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    prio_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) prio_idx = ID_W'(i);
    end
  end

  // Next-state logic for the CPU handshake; the cause is frozen once latched.
  always_comb begin
    state_nxt = state_q;
    cause_nxt = cause_q;
    ack       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          cause_nxt = prio_idx;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (Inta) begin
          ack       = 1'b1;
          state_nxt = INSVC;
        end
      end
      INSVC: begin
        if (Eret) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-hot clear for the acknowledged cause.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr_vec[i] = ack && (cause_q == ID_W'(i));
    end
  end

  // State and latched cause registers.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= IDLE;
      cause_q <= '0;
    end else begin
      state_q <= state_nxt;
      cause_q <= cause_nxt;
    end
  end

  // Pending register: a new edge on the same cycle as its clear keeps the bit set.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) pending_q <= '0;
    else     pending_q <= (pending_q & ~clr_vec) | edges;
  end

  // CPU-written enable mask.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr)       enable_q <= '0;
    else if (EnWe) enable_q <= EnWdata;
  end

  assign Intr      = (state_q == REQ);
  assign InService = (state_q == INSVC);
  assign IntCause  = cause_q;
  assign Pending   = pending_q;
  assign EnRdata   = enable_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller. Expected request causes go into a
// scoreboard queue; a monitor compares them whenever Intr rises. Register
// state (Pending, InService, mask) is checked directly with check().
module tb_irq_controller;

  localparam int N = 8;
  localparam int W = 3;

  logic         Clk = 1'b0;
  logic         Clr;
  logic [N-1:0] IrqIn;
  logic         EnWe;
  logic [N-1:0] EnWdata;
  logic [N-1:0] EnRdata;
  logic [N-1:0] Pending;
  logic         Intr;
  logic [W-1:0] IntCause;
  logic         Inta;
  logic         Eret;
  logic         InService;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] exp_cause;
  logic         intr_q = 1'b0;

  irq_controller #(.NUM_IRQ(N), .ID_W(W)) dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .IrqIn     (IrqIn),
    .EnWe      (EnWe),
    .EnWdata   (EnWdata),
    .EnRdata   (EnRdata),
    .Pending   (Pending),
    .Intr      (Intr),
    .IntCause  (IntCause),
    .Inta      (Inta),
    .Eret      (Eret),
    .InService (InService)
  );

  always #5 Clk = ~Clk;

  // Monitor: every rising Intr must match the next expected cause.
  always @(negedge Clk) begin
    if (Intr && !intr_q) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected_req: got cause %0d, expected no request", IntCause);
      end else begin
        exp_cause = sb_q.pop_front();
        if (IntCause !== exp_cause) begin
          n_errors++;
          $display("FAIL sb_cause: got %0d expected %0d", IntCause, exp_cause);
        end
      end
    end
    intr_q = Intr;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Clr = 1'b1; IrqIn = '0; EnWe = 1'b0; EnWdata = '0; Inta = 1'b0; Eret = 1'b0;
    tick(2);
    Clr = 1'b0;
  endtask

  task automatic set_mask(input logic [N-1:0] m);
    EnWe = 1'b1; EnWdata = m;
    tick(1);
    EnWe = 1'b0;
  endtask

  task automatic pulse_inta();
    Inta = 1'b1; tick(1); Inta = 1'b0;
  endtask

  task automatic pulse_eret();
    Eret = 1'b1; tick(1); Eret = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- Reset and mask ----------------
    Clr = 1'b1; IrqIn = '0; EnWe = 1'b0; EnWdata = '0; Inta = 1'b0; Eret = 1'b0;
    tick(2);
    check("rst_pending",   Pending,   8'h00);
    check("rst_enable",    EnRdata,   8'h00);
    check("rst_intr",      Intr,      1'b0);
    check("rst_insvc",     InService, 1'b0);
    check("rst_cause",     IntCause,  3'd0);
    IrqIn = 8'h01;
    tick(1);
    check("rst_hold_pending", Pending, 8'h00);
    Clr = 1'b0;                      // next edge is k
    tick(2);
    check("mask_pending_k1", Pending, 8'h00);
    tick(1);
    check("mask_pending_k2", Pending, 8'h01);
    tick(3);
    check("mask_intr_off", Intr, 1'b0);
    pulse_inta();                    // ignored outside REQ
    check("inta_idle_ignored", Pending, 8'h01);
    sb_q.push_back(3'd0);
    set_mask(8'h01);
    check("mask_rdata", EnRdata, 8'h01);
    check("mask_next_cycle", Intr, 1'b0);
    tick(1);
    check("mask_intr_on", Intr, 1'b1);
    check("mask_cause",   IntCause, 3'd0);
    pulse_inta();
    check("ack_insvc",   InService, 1'b1);
    check("ack_intr",    Intr,      1'b0);
    check("ack_pending", Pending,   8'h00);
    pulse_eret();
    check("eret_idle", InService, 1'b0);
    tick(2);
    check("level_no_reevent", Intr, 1'b0);

    // ---------------- Priority ----------------
    do_reset();
    sb_q.push_back(3'd2);
    sb_q.push_back(3'd5);
    IrqIn = 8'h24; EnWe = 1'b1; EnWdata = 8'hFF;
    tick(1);
    EnWe = 1'b0;
    tick(3);
    check("prio_intr",  Intr,     1'b1);
    check("prio_cause", IntCause, 3'd2);
    pulse_eret();                    // ignored outside INSVC
    check("eret_req_ignored", Intr, 1'b1);
    pulse_inta();
    check("prio_pending", Pending, 8'h20);
    pulse_eret();
    check("prio_gap_after_eret", Intr, 1'b0);
    tick(1);
    check("prio_second_intr",  Intr,     1'b1);
    check("prio_second_cause", IntCause, 3'd5);
    pulse_inta();
    check("prio_drained", Pending, 8'h00);
    pulse_eret();

    // ---------------- Latency ----------------
    do_reset();
    set_mask(8'h08);
    sb_q.push_back(3'd3);
    IrqIn = 8'h08;                   // next edge is k
    tick(2);
    check("lat_pending_k1", Pending, 8'h00);
    tick(1);
    check("lat_pending_k2", Pending, 8'h08);
    check("lat_intr_k2",    Intr,    1'b0);
    tick(1);
    check("lat_intr_k3",  Intr,     1'b1);
    check("lat_cause_k3", IntCause, 3'd3);
    pulse_inta();
    check("lat_insvc_k4",   InService, 1'b1);
    check("lat_pending_k4", Pending,   8'h00);
    pulse_eret();

    // ---------------- Frozen cause ----------------
    do_reset();
    sb_q.push_back(3'd4);
    sb_q.push_back(3'd1);
    IrqIn = 8'h10; EnWe = 1'b1; EnWdata = 8'hFF;
    tick(1);
    EnWe = 1'b0;
    tick(3);
    check("frz_cause_init", IntCause, 3'd4);
    IrqIn = 8'h12;
    tick(4);
    check("frz_pending_both", Pending,  8'h12);
    check("frz_cause_hold",   IntCause, 3'd4);
    set_mask(8'h02);                 // mask change does not withdraw
    tick(1);
    check("frz_intr_hold",  Intr,     1'b1);
    check("frz_cause_mask", IntCause, 3'd4);
    pulse_inta();
    check("frz_pending_after", Pending, 8'h02);
    pulse_eret();
    tick(1);
    check("frz_next_cause", IntCause, 3'd1);
    pulse_inta();
    pulse_eret();

    // ---------------- Set-wins and one-shot ----------------
    do_reset();
    set_mask(8'h01);
    sb_q.push_back(3'd0);
    sb_q.push_back(3'd0);
    IrqIn = 8'h01;
    tick(4);
    check("sw_req", Intr, 1'b1);
    IrqIn = 8'h00;
    tick(3);                         // sync and history back to 0
    IrqIn = 8'h01;                   // edge seen one cycle later, sets at 3rd edge
    tick(2);
    pulse_inta();                    // clear lands on the same edge as the set
    check("sw_pending_kept", Pending,   8'h01);
    check("sw_insvc",        InService, 1'b1);
    pulse_eret();
    tick(1);
    check("sw_rerequest", Intr, 1'b1);
    pulse_inta();
    tick(20);
    check("oneshot_pending", Pending, 8'h00);
    pulse_eret();
    tick(3);
    check("oneshot_no_req", Intr, 1'b0);

    // ---------------- Async reset mid-service ----------------
    do_reset();
    set_mask(8'h01);
    sb_q.push_back(3'd0);
    IrqIn = 8'h01;
    tick(4);
    pulse_inta();
    check("ar_insvc_before", InService, 1'b1);
    IrqIn = 8'h03;
    tick(3);
    check("ar_pending_before", Pending, 8'h02);
    #2;
    Clr = 1'b1;
    #1;
    check("ar_insvc",   InService, 1'b0);
    check("ar_intr",    Intr,      1'b0);
    check("ar_pending", Pending,   8'h00);
    check("ar_enable",  EnRdata,   8'h00);
    @(posedge Clk); #1;
    Clr = 1'b0; IrqIn = '0;
    pulse_eret();
    check("ar_eret_ignored", InService, 1'b0);
    tick(3);
    check("ar_idle", Intr, 1'b0);

    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
